// File: rtl/stream_demux2_8.sv
// stream_demux2_8
//   Steers an 8-bit framed valid/ready byte stream to one of two outputs,
//   one whole frame at a time. The destination is taken from sel on the
//   first beat of a frame and held until that frame's last beat. Each output
//   owns a small FIFO so a stalled consumer on one side cannot disturb the
//   other, and each output has a wrapping beat counter for analyzer status.
//
// Ports
//   clk, reset                 clock; asynchronous active-high reset
//   in_data/in_last/in_valid   input beat; in_ready = target FIFO not full
//   sel                        destination (0 = out0, 1 = out1), frame start only
//   outN_data/outN_last        head entry of FIFO N (zero while empty)
//   outN_valid/outN_ready      FIFO N non-empty / consumer accepts
//   cnt_clr                    synchronous clear of both beat counters
//   beats0/beats1              beats popped from out0/out1
//   frame_active               high while a multi-beat frame is in progress
//   locked_sel                 destination of the current/most recent frame
module stream_demux2_8 #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  sel,
  output logic [DATA_WIDTH-1:0] out0_data,
  output logic                  out0_last,
  output logic                  out0_valid,
  input  logic                  out0_ready,
  output logic [DATA_WIDTH-1:0] out1_data,
  output logic                  out1_last,
  output logic                  out1_valid,
  input  logic                  out1_ready,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  beats0,
  output logic [CNT_WIDTH-1:0]  beats1,
  output logic                  frame_active,
  output logic                  locked_sel
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_WIDTH + 1;

  typedef enum logic {S_IDLE, S_FRAME} state_t;

  state_t               state_q;
  logic                 locked_sel_q;

  logic [EW-1:0]        mem_q    [2][FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q [2];
  logic [PW-1:0]        wr_ptr_d [2];
  logic [PW-1:0]        rd_ptr_q [2];
  logic [PW-1:0]        rd_ptr_d [2];
  logic [PW:0]          cnt_q    [2];
  logic [PW:0]          cnt_d    [2];
  logic [CNT_WIDTH-1:0] beats_q  [2];
  logic [CNT_WIDTH-1:0] beats_d  [2];
  logic [EW-1:0]        head     [2];

  logic       target;
  logic       accept;
  logic [1:0] full;
  logic [1:0] nonempty;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] out_rdy;

  assign out_rdy = {out1_ready, out0_ready};

  // Destination follows sel only between frames; mid-frame it is frozen.
  assign target = (state_q == S_FRAME) ? locked_sel_q : sel;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      full[i]     = (cnt_q[i] == (PW+1)'(FIFO_DEPTH));
      nonempty[i] = (cnt_q[i] != '0);
      head[i]     = nonempty[i] ? mem_q[i][rd_ptr_q[i]] : '0;
    end
  end

  // A full FIFO deliberately gets no credit from a same-cycle pop, which
  // keeps in_ready free of any path from the output-side ready inputs.
  assign in_ready = ~full[target];
  assign accept   = in_valid & in_ready;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      push[i] = accept & (target == 1'(i));
      pop[i]  = nonempty[i] & out_rdy[i];

      wr_ptr_d[i] = push[i] ? wr_ptr_q[i] + PW'(1) : wr_ptr_q[i];
      rd_ptr_d[i] = pop[i]  ? rd_ptr_q[i] + PW'(1) : rd_ptr_q[i];

      cnt_d[i] = cnt_q[i];
      if (push[i] && !pop[i]) cnt_d[i] = cnt_q[i] + (PW+1)'(1);
      else if (pop[i] && !push[i]) cnt_d[i] = cnt_q[i] - (PW+1)'(1);

      // Clear wins over a same-cycle increment; the counter wraps naturally.
      beats_d[i] = beats_q[i];
      if (cnt_clr) beats_d[i] = '0;
      else if (pop[i]) beats_d[i] = beats_q[i] + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      locked_sel_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
        beats_q[i]  <= '0;
      end
    end else begin
      if (accept) begin
        if (state_q == S_IDLE) begin
          locked_sel_q <= sel;
          state_q      <= in_last ? S_IDLE : S_FRAME;
        end else if (in_last) begin
          state_q <= S_IDLE;
        end
      end
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
        beats_q[i]  <= beats_d[i];
      end
    end
  end

  // Storage is not reset: empty FIFOs mask their head to zero instead.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= {in_last, in_data};
    end
  end

  assign out0_data    = head[0][DATA_WIDTH-1:0];
  assign out0_last    = head[0][DATA_WIDTH];
  assign out0_valid   = nonempty[0];
  assign out1_data    = head[1][DATA_WIDTH-1:0];
  assign out1_last    = head[1][DATA_WIDTH];
  assign out1_valid   = nonempty[1];
  assign beats0       = beats_q[0];
  assign beats1       = beats_q[1];
  assign frame_active = (state_q == S_FRAME);
  assign locked_sel   = locked_sel_q;

endmodule

// File: doc/stream_demux2_8.md
Name: stream_demux2_8

Overview:
- Byte-stream demultiplexer: the steering counterpart of the analyzer's 2:1 byte mux.
- Accepts one 8-bit framed stream with valid/ready and routes each whole frame to one of two output streams.
- Routing is chosen by `sel`, which is sampled on the first beat of a frame and locked until that frame's last beat.
- Each output has a small FIFO so one stalled consumer does not corrupt the frame in flight; per-output beat counters feed analyzer status.

Parameters:
DATA_WIDTH, 8, width of data path
FIFO_DEPTH, 2, entries per output FIFO; power of two, minimum 2
CNT_WIDTH, 16, width of per-output beat counters

Ports:
clk  in  1  system clock; all logic rising-edge
reset  in  1  asynchronous, active-high reset
in_data  in  DATA_WIDTH  input beat data
in_last  in  1  marks final beat of a frame
in_valid  in  1  input beat present
in_ready  out  1  block can accept a beat
sel  in  1  destination (0 = out0, 1 = out1); sampled at frame start only
out0_data  out  DATA_WIDTH  output 0 head data
out0_last  out  1  output 0 head last flag
out0_valid  out  1  output 0 FIFO non-empty
out0_ready  in  1  output 0 consumer accepts
out1_data / out1_last / out1_valid / out1_ready  same as out0 for output 1
cnt_clr  in  1  synchronous clear of beat counters
beats0  out  CNT_WIDTH  beats delivered on out0
beats1  out  CNT_WIDTH  beats delivered on out1
frame_active  out  1  high while in FRAME state
locked_sel  out  1  destination of current frame

Behaviour:
- Interface: one clock, `clk`. Reset `reset` is asynchronous and active-high.
- Reset values:
  - FSM = IDLE, both FIFOs empty.
  - out0_valid = out1_valid = 0; out*_data and out*_last = 0.
  - beats0 = beats1 = 0; frame_active = 0; locked_sel = 0.
  - in_ready becomes 1 as soon as reset releases, because both FIFOs are empty.
- Target: target = sel in IDLE, locked_sel in FRAME.
- in_ready: combinational = target FIFO not full.
  - Must not depend on in_valid.
  - Must not use a same-cycle read of a full FIFO; a full FIFO with a simultaneous pop still gives in_ready = 0.
- Accept: in_valid && in_ready. An accepted beat {in_data, in_last} is written into the target FIFO.
- FSM:
  - IDLE, accept with in_last = 0: locked_sel <= sel, go to FRAME.
  - IDLE, accept with in_last = 1: single-beat frame, stay in IDLE, locked_sel <= sel.
  - FRAME, accept with in_last = 1: go to IDLE.
  - FRAME: sel changes are ignored.
- Output side:
  - outN_valid = FIFO N non-empty; outN_data and outN_last present the head entry.
  - Pop on outN_valid && outN_ready.
  - Minimum latency from input accept to outN_valid is 1 cycle; no combinational input-to-output path.
- FIFO: circular buffer with wrap-around pointers and an occupancy count (0..FIFO_DEPTH). A simultaneous push and pop leaves the count unchanged.
- Ordering: beats within each output strictly FIFO. A frame on out1 may be emitted while an earlier out0 frame is stalled; there is no cross-output ordering.
- Counters:
  - beatsN increments on each outN pop.
  - Wraps from 2^CNT_WIDTH-1 to 0.
  - cnt_clr forces both counters to 0 and takes priority over a same-cycle increment.
- Reset mid-frame: FIFO contents and the partial frame are discarded; the FSM returns to IDLE and the next beat is treated as a frame start.
- The block checks no protocol errors. A frame without in_last keeps the FSM in FRAME indefinitely.

Test Plan:
- Reset then idle: assert reset asynchronously mid-cycle -> all outputs are at reset values immediately; after release, in_ready = 1, outN_valid = 0.
- Single-beat routing: sel = 1, send 0xA5 with in_last = 1, out1_ready = 1 -> out1_valid high the next cycle with data 0xA5, last = 1; beats1 = 1; out0 untouched.
- Sel lock: sel = 0 on beat 0x10, toggle sel to 1 during beats 0x11 and 0x12 (last) -> all three beats appear on out0 in order; locked_sel = 0, frame_active = 1 during the frame; next frame follows sel.
- Backpressure: out0_ready = 0, send 4-beat frame to out0 with FIFO_DEPTH = 2 -> in_ready drops after 2 accepts; raise out0_ready -> remaining beats flow, no loss or duplication, beats0 = 4.
- Independent outputs: out0 stalled and full, sel = 1 with FSM in IDLE -> in_ready = 1, an out1 frame passes through while out0 holds its data.
- Counter edge and reset mid-frame: preload beats1 to 0xFFFF via traffic, pop one -> 0x0000; cnt_clr concurrent with a pop -> 0. Assert reset after 2 of 3 beats -> FIFOs empty, FSM IDLE, the next beat starts a new frame on the current sel.
